// File: rtl/abc_gate.sv
// abc_gate: three-input select function y = a&b | ~b&c, with a registered
// copy, single-cycle edge pulses and a saturating count of high cycles.
//
// The combinational path is the only thing glue logic should tap; the
// registered outputs all share one clock and one asynchronous active-low
// reset, so downstream synchronous logic sees a coherent snapshot of y.
module abc_gate #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             y,
   output logic             y_q,
   output logic             y_rise,
   output logic             y_fall,
   output logic [CNT_W-1:0] hi_cnt
);

   // All-ones is the saturation point; one is the increment step.
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Select function plus the consensus term a&c: when a=c=1 the output is
   // held high by a&c while b changes, so the mux cannot glitch low.
   assign y = (a & b) | (~b & c) | (a & c);

   // Registered copy, edge pulses and saturating high-cycle counter.
   // Edge pulses compare the new sample against the previous y_q, so after
   // reset a high first sample produces a rise pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= 1'b0;
         y_rise <= 1'b0;
         y_fall <= 1'b0;
         hi_cnt <= '0;
      end else begin
         y_q    <= y;
         y_rise <= y & ~y_q;
         y_fall <= ~y & y_q;
         if (y && (hi_cnt != CNT_MAX)) begin
            hi_cnt <= hi_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_abc_gate.sv
// Directed testbench for abc_gate: one task per scenario, inline checks,
// a wide-counter instance and a 2-bit-counter instance sharing inputs.
module tb_abc_gate;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       a, b, c;

   logic       y, y_q, y_rise, y_fall;
   logic [15:0] hi_cnt;
   logic       s_y, s_y_q, s_y_rise, s_y_fall;
   logic [1:0] s_hi_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic haz_win    = 1'b0;
   logic haz_glitch = 1'b0;

   abc_gate #(.CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
      .y(y), .y_q(y_q), .y_rise(y_rise), .y_fall(y_fall), .hi_cnt(hi_cnt)
   );

   abc_gate #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
      .y(s_y), .y_q(s_y_q), .y_rise(s_y_rise), .y_fall(s_y_fall), .hi_cnt(s_hi_cnt)
   );

   // Clock: gated so the combinational test can run with clk idle.
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Glitch monitor for the hazard window.
   always @(y) begin
      if (haz_win && (y !== 1'b1)) haz_glitch = 1'b1;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      {a, b, c} = 3'b111;
      #1;
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b000 || hi_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got q/r/f=%b%b%b cnt=%0d, want 000 cnt=0", y_q, y_rise, y_fall, hi_cnt);
      end
      n_tests++;
      if ({s_y_q, s_y_rise, s_y_fall} !== 3'b000 || s_hi_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_regs_sat: got q/r/f=%b%b%b cnt=%0d, want 000 cnt=0", s_y_q, s_y_rise, s_y_fall, s_hi_cnt);
      end
   endtask

   // Exhaustive truth table with clk idle and reset still asserted.
   task automatic test_comb();
      logic [7:0] tbl;
      tbl = 8'b1110_0010; // bit i = y for abc = i
      for (int i = 0; i < 8; i++) begin
         {a, b, c} = i[2:0];
         #10;
         n_tests++;
         if (y !== tbl[i] || s_y !== tbl[i]) begin
            n_fail++;
            $display("FAIL comb abc=%03b: got y=%b/%b, want %b", i[2:0], y, s_y, tbl[i]);
         end
      end
      n_tests++;
      if (y_q !== 1'b0 || hi_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL comb_no_reg: got y_q=%b cnt=%0d, want 0 0", y_q, hi_cnt);
      end
   endtask

   task automatic test_register();
      do_reset();
      {a, b, c} = 3'b110;
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b110 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL reg_rise: got q/r/f=%b%b%b cnt=%0d, want 110 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
      {a, b, c} = 3'b010;
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b001 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL reg_fall: got q/r/f=%b%b%b cnt=%0d, want 001 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b000 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL reg_idle: got q/r/f=%b%b%b cnt=%0d, want 000 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
   endtask

   task automatic test_counter();
      do_reset();
      {a, b, c} = 3'b111;
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_tests++;
         if (hi_cnt !== k[15:0] || y_q !== 1'b1 || y_rise !== (k == 1) || y_fall !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_up[%0d]: got cnt=%0d q/r/f=%b%b%b, want cnt=%0d q=1 r=%b f=0",
                     k, hi_cnt, y_q, y_rise, y_fall, k, (k == 1));
         end
      end
      {a, b, c} = 3'b000;
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_tests++;
         if (hi_cnt !== 16'd5 || y_q !== 1'b0 || y_fall !== (k == 1) || y_rise !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_hold[%0d]: got cnt=%0d q/r/f=%b%b%b, want cnt=5 q=0 r=0 f=%b",
                     k, hi_cnt, y_q, y_rise, y_fall, (k == 1));
         end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_s;
      do_reset();
      {a, b, c} = 3'b101;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_s = (k < 3) ? k[1:0] : 2'd3;
         n_tests++;
         if (s_hi_cnt !== exp_s || hi_cnt !== k[15:0]) begin
            n_fail++;
            $display("FAIL sat[%0d]: got cnt2=%0d cnt16=%0d, want cnt2=%0d cnt16=%0d",
                     k, s_hi_cnt, hi_cnt, exp_s, k);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      {a, b, c} = 3'b111;
      repeat (4) tick();
      n_tests++;
      if (hi_cnt !== 16'd4 || y_q !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_pre: got cnt=%0d y_q=%b, want cnt=4 y_q=1", hi_cnt, y_q);
      end
      #2 rst_n = 1'b0;   // mid-cycle, well before the next rising edge
      #1;
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b000 || hi_cnt !== 16'd0 || s_hi_cnt !== 2'd0 || y !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_clear: got q/r/f=%b%b%b cnt=%0d cnt2=%0d y=%b, want 000 0 0 y=1",
                  y_q, y_rise, y_fall, hi_cnt, s_hi_cnt, y);
      end
      {a, b, c} = 3'b010;
      #1;
      n_tests++;
      if (y !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_y_track0: got y=%b, want 0", y);
      end
      {a, b, c} = 3'b001;
      #1;
      n_tests++;
      if (y !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_y_track1: got y=%b, want 1", y);
      end
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b000 || hi_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL arst_held: got q/r/f=%b%b%b cnt=%0d, want 000 cnt=0", y_q, y_rise, y_fall, hi_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      {a, b, c} = 3'b111;
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b110 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL arst_restart: got q/r/f=%b%b%b cnt=%0d, want 110 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
   endtask

   // A pulse on y strictly between edges must leave no registered trace.
   task automatic test_between_edges();
      {a, b, c} = 3'b000;
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b001 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL between_pre: got q/r/f=%b%b%b cnt=%0d, want 001 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
      #3 {a, b, c} = 3'b110;
      #3 {a, b, c} = 3'b000;
      tick();
      n_tests++;
      if ({y_q, y_rise, y_fall} !== 3'b000 || hi_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL between_edges: got q/r/f=%b%b%b cnt=%0d, want 000 cnt=1", y_q, y_rise, y_fall, hi_cnt);
      end
   endtask

   task automatic test_hazard();
      int bad;
      bad = 0;
      {a, b, c} = 3'b101;
      #1;
      haz_glitch = 1'b0;
      haz_win    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b = ~b;
         #1;
         if (y !== 1'b1) bad++;
      end
      haz_win = 1'b0;
      n_tests++;
      if (bad != 0 || haz_glitch !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard: got %0d low samples glitch=%b, want 0 and 0", bad, haz_glitch);
      end
   endtask

   initial begin
      clk_en = 1'b0;
      rst_n  = 1'b0;
      {a, b, c} = 3'b000;
      test_reset();
      test_comb();
      clk_en = 1'b1;
      test_register();
      test_counter();
      test_saturation();
      test_async_reset();
      test_between_edges();
      test_hazard();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
